dmem_ctl: RTL

Sequencing controller for the single-port data memory behind the pipeline's MEM stage. It turns the MEM stage's load/store strobes into a req/ack transaction toward a variable-latency memory and stalls the pipeline until the access completes. It shares that memory with one external requester (debug/DMA port) using pipeline-first priority with a starvation bound. It sits between the MEM stage (ahead of the MEM/WB register) and the data memory.

---
 rtl/dmem_ctl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/dmem_ctl.sv
// Data-memory sequencer for the MEM stage: pipeline-first arbitration against one external
// requester with a starvation bound. Optional transaction timeout under DMEM_CTL_TIMEOUT_EN.
module dmem_ctl #(
  parameter int unsigned X_MAX_WAIT = 8,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  // pipeline MEM stage
  input  logic        MEM_read,
  input  logic        MEM_write,
  input  logic [31:0] MEM_addr,
  input  logic [31:0] MEM_wdata,
  output logic [31:0] MEM_rdata,
  output logic        MEM_stall,
  // external requester
  input  logic        X_req,
  input  logic        X_we,
  input  logic [31:0] X_addr,
  input  logic [31:0] X_wdata,
  output logic        X_gnt,
  output logic [31:0] X_rdata,
  // memory
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  typedef enum logic [2:0] {StIdle, StBusyP, StBusyX, StDoneP, StDoneX} state_e;

  localparam logic [7:0] MaxWait = 8'(X_MAX_WAIT);

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] pipe_rdata_q, pipe_rdata_d;
  logic [31:0] x_rdata_q, x_rdata_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        err_q, err_d;

  logic pipe_req;
  logic x_wins;
  logic pipe_wins;
  logic tmo_hit;

  assign pipe_req  = MEM_read | MEM_write;
  assign x_wins    = X_req & ((wait_cnt_q >= MaxWait) | ~pipe_req);
  assign pipe_wins = pipe_req & ~x_wins;

`ifdef DMEM_CTL_TIMEOUT_EN
  localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        busy;

  assign busy = (state_q == StBusyP) | (state_q == StBusyX);

  always_comb begin
    tmo_cnt_d = busy ? tmo_cnt_q + 16'd1 : 16'd0;
  end

  // An ack arriving on the limit cycle takes precedence over the abort.
  assign tmo_hit = busy & ~mem_ack & (tmo_cnt_q == TmoLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= 16'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  localparam logic [15:0] TimeoutIgnored = 16'(TIMEOUT);

  logic unused_timeout;

  assign unused_timeout = ^TimeoutIgnored;
  assign tmo_hit        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (x_wins) begin
          state_d = StBusyX;
        end else if (pipe_wins) begin
          state_d = StBusyP;
        end
      end
      StBusyP: begin
        if (mem_ack || tmo_hit) begin
          state_d = StDoneP;
        end
      end
      StBusyX: begin
        if (mem_ack || tmo_hit) begin
          state_d = StDoneX;
        end
      end
      StDoneP, StDoneX: state_d = StIdle;
      default:          state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; the stall is combinational so it rises with the strobe.
  always_comb begin
    MEM_stall = pipe_req & (state_q != StDoneP);
    X_gnt     = (state_q == StDoneX);
  end

  // Request fields, read data, starvation counter and error pulse
  always_comb begin
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    pipe_rdata_d = pipe_rdata_q;
    x_rdata_d    = x_rdata_q;
    wait_cnt_d   = X_req ? wait_cnt_q : 8'd0;
    err_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (x_wins) begin
          mem_req_d   = 1'b1;
          mem_we_d    = X_we;
          mem_addr_d  = X_addr;
          mem_wdata_d = X_wdata;
          wait_cnt_d  = 8'd0;
        end else if (pipe_wins) begin
          mem_req_d   = 1'b1;
          mem_we_d    = MEM_write;
          mem_addr_d  = MEM_addr;
          mem_wdata_d = MEM_wdata;
          // The pipeline only beats a waiting X below MaxWait, so this saturates there.
          if (X_req) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      StBusyP, StBusyX: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            if (state_q == StBusyP) begin
              pipe_rdata_d = mem_rdata;
            end else begin
              x_rdata_d = mem_rdata;
            end
          end
        end else if (tmo_hit) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (state_q == StBusyP) begin
            pipe_rdata_d = 32'd0;
          end else begin
            x_rdata_d = 32'd0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      pipe_rdata_q <= 32'd0;
      x_rdata_q    <= 32'd0;
      wait_cnt_q   <= 8'd0;
      err_q        <= 1'b0;
    end else begin
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      pipe_rdata_q <= pipe_rdata_d;
      x_rdata_q    <= x_rdata_d;
      wait_cnt_q   <= wait_cnt_d;
      err_q        <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign MEM_rdata = pipe_rdata_q;
  assign X_rdata   = x_rdata_q;
  assign err       = err_q;

endmodule
